// File: rtl/alu_div_pkg.sv
// Shared types for the alu_div restoring divider.
// DIV_SIGNED_EN (optional) enables signed DIV support in alu_div.
package alu_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        ITER  = 2'd2,
        FIXUP = 2'd3
    } div_state_e;

    localparam logic [4:0] DIV_ITER_WIDE   = 5'd16;
    localparam logic [4:0] DIV_ITER_NARROW = 5'd8;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the alu_div divider.
// Narrow mode treats the partial remainder as 8 bits.
module div_step
    import alu_div_pkg::*;
(
    input  logic [15:0] rem_i,
    input  logic        bit_i,
    input  logic [15:0] dvsr_i,
    input  logic        wide_i,
    output logic [15:0] rem_o,
    output logic        qbit_o
);

    logic [16:0] shf;
    logic [16:0] diff;

    always_comb begin
        shf    = wide_i ? {rem_i, bit_i} : {8'd0, rem_i[7:0], bit_i};
        diff   = shf - {1'b0, dvsr_i};
        qbit_o = (shf >= {1'b0, dvsr_i});
        rem_o  = qbit_o ? diff[15:0] : shf[15:0];
    end

endmodule

// File: rtl/alu_div.sv
// Multi-cycle 32/16 and 16/8 restoring divider (DIVU, and DIV when
// DIV_SIGNED_EN is defined); IDLE -> PREP -> ITER x N -> FIXUP.
module alu_div
    import alu_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic        wide,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_error
);

    div_state_e  state_q, state_d;
    logic        wide_q;
    logic [31:0] dvd_q;
    logic [15:0] dvs_q;
    logic [15:0] prem_q, pquo_q;
    logic [4:0]  cnt_q;
    logic [15:0] res_quo_q, res_rem_q;
    logic        err_q, done_q;

    logic [31:0] dvd_mag;
    logic [15:0] dvs_mag;
    logic        prep_err;
    logic        accept;
    logic [15:0] step_rem;
    logic        step_q;
    logic [15:0] fx_q, fx_r;
    logic        fx_err;

`ifdef DIV_SIGNED_EN
    logic        sgn_q;
    logic        dvd_neg, dvs_neg, qneg;
    logic [15:0] lim;

    always_comb begin
        dvd_neg = sgn_q & (wide_q ? dvd_q[31] : dvd_q[15]);
        dvs_neg = sgn_q & (wide_q ? dvs_q[15] : dvs_q[7]);
        qneg    = dvd_neg ^ dvs_neg;
        lim     = wide_q ? 16'h7FFF : 16'h007F;
        dvd_mag = dvd_neg ? (32'd0 - dvd_q) : dvd_q;
        dvs_mag = dvs_neg ? (16'd0 - dvs_q) : dvs_q;
        if (!wide_q) begin
            dvd_mag[31:16] = 16'd0;
            dvs_mag[15:8]  = 8'd0;
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = signed_op;
    assign dvd_mag = wide_q ? dvd_q : {16'd0, dvd_q[15:0]};
    assign dvs_mag = wide_q ? dvs_q : {8'd0, dvs_q[7:0]};
`endif

    // Quotient must fit the result width, so the high half must be below the divisor.
    assign prep_err = (dvs_mag == 16'd0) ||
                      (wide_q ? (dvd_mag[31:16] >= dvs_mag)
                              : (dvd_mag[15:8] >= dvs_mag[7:0]));

    assign accept = start && !done_q;

    div_step u_step (
        .rem_i  (prem_q),
        .bit_i  (wide_q ? pquo_q[15] : pquo_q[7]),
        .dvsr_i (dvs_mag),
        .wide_i (wide_q),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    always_comb begin
        fx_q   = wide_q ? pquo_q : {8'd0, pquo_q[7:0]};
        fx_r   = prem_q;
        fx_err = 1'b0;
`ifdef DIV_SIGNED_EN
        if (sgn_q) begin
            fx_err = qneg ? (fx_q > (lim + 16'd1)) : (fx_q > lim);
            if (qneg)
                fx_q = 16'd0 - fx_q;
            if (dvd_neg)
                fx_r = 16'd0 - fx_r;
            if (!wide_q) begin
                fx_q[15:8] = 8'd0;
                fx_r[15:8] = 8'd0;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = PREP;
            PREP:    state_d = prep_err ? IDLE : ITER;
            ITER:    if (cnt_q == 5'd1) state_d = FIXUP;
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wide_q    <= 1'b0;
            dvd_q     <= 32'd0;
            dvs_q     <= 16'd0;
            prem_q    <= 16'd0;
            pquo_q    <= 16'd0;
            cnt_q     <= 5'd0;
            res_quo_q <= 16'd0;
            res_rem_q <= 16'd0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: if (accept) begin
                    wide_q <= wide;
                    dvd_q  <= dividend;
                    dvs_q  <= divisor;
`ifdef DIV_SIGNED_EN
                    sgn_q  <= signed_op;
`endif
                end
                PREP: if (prep_err) begin
                    err_q  <= 1'b1;
                    done_q <= 1'b1;
                end else begin
                    prem_q <= wide_q ? dvd_mag[31:16] : {8'd0, dvd_mag[15:8]};
                    pquo_q <= wide_q ? dvd_mag[15:0] : {8'd0, dvd_mag[7:0]};
                    cnt_q  <= wide_q ? DIV_ITER_WIDE : DIV_ITER_NARROW;
                end
                ITER: begin
                    prem_q <= step_rem;
                    pquo_q <= {pquo_q[14:0], step_q};
                    cnt_q  <= cnt_q - 5'd1;
                end
                FIXUP: begin
                    err_q <= fx_err;
                    if (!fx_err) begin
                        res_quo_q <= fx_q;
                        res_rem_q <= fx_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIXUP results are shown combinationally so done lands N+2 cycles after start.
    assign busy      = (state_q != IDLE);
    assign done      = done_q | (state_q == FIXUP);
    assign quotient  = ((state_q == FIXUP) && !fx_err) ? fx_q : res_quo_q;
    assign remainder = ((state_q == FIXUP) && !fx_err) ? fx_r : res_rem_q;
    assign div_error = (state_q == FIXUP) ? fx_err : err_q;

endmodule

// File: tb/tb_alu_div.sv
// Directed self-checking bench for alu_div (signed cases follow DIV_SIGNED_EN).
module tb_alu_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic        wide;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_error;

    int ncmp;
    int nbad;

    int          lat;
    logic [15:0] q, r;
    logic        e, bz;

    alu_div dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .wide      (wide),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_error (div_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        ncmp++;
        assert (o === x) else begin
            nbad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    // Launch one op; inputs are scrambled after acceptance, start is
    // re-pulsed after the pk-th edge, results captured when done rises.
    task automatic do_op(input logic s, input logic w, input logic [31:0] a,
                         input logic [15:0] b, input int pk,
                         output int lt, output logic [15:0] qo,
                         output logic [15:0] ro, output logic eo,
                         output logic bzo);
        @(negedge clk);
        signed_op = s;
        wide      = w;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        lt = 0;
        while (lt < 40) begin
            @(posedge clk);
            lt++;
            #1;
            start     = (lt == pk);
            signed_op = ~s;
            wide      = ~w;
            dividend  = ~a;
            divisor   = ~b;
            if (done) break;
        end
        qo = quotient;
        ro = remainder;
        eo = div_error;
        @(posedge clk);
        #1;
        start = 1'b0;
        bzo = busy | done;
    endtask

    initial begin
        ncmp = 0;
        nbad = 0;
        reset = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        wide = 1'b0;
        dividend = 32'd0;
        divisor = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quo", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_err", div_error, 0);
        #2 reset = 1'b0;

        do_op(0, 1, 32'h0001_0000, 16'h0003, 5, lat, q, r, e, bz);
        chk("divu_w_lat", lat, 18);
        chk("divu_w_quo", q, 32'h5555);
        chk("divu_w_rem", r, 32'h0001);
        chk("divu_w_err", e, 0);
        chk("divu_w_pulse", bz, 0);

        do_op(0, 1, 32'h1234_5678, 16'h0000, 2, lat, q, r, e, bz);
        chk("dz_lat", lat, 2);
        chk("dz_err", e, 1);
        chk("dz_quo_hold", q, 32'h5555);
        chk("dz_rem_hold", r, 32'h0001);
        chk("dz_start_ign", bz, 0);

        do_op(0, 1, 32'h0003_0000, 16'h0002, 0, lat, q, r, e, bz);
        chk("ovf_prep_lat", lat, 2);
        chk("ovf_prep_err", e, 1);
        chk("ovf_prep_quo", q, 32'h5555);

        do_op(0, 0, 32'hABCD_00C8, 16'hFF07, 10, lat, q, r, e, bz);
        chk("divu_n_lat", lat, 10);
        chk("divu_n_quo", q, 32'h001C);
        chk("divu_n_rem", r, 32'h0004);
        chk("divu_n_err", e, 0);
        chk("divu_n_start_ign", bz, 0);

        do_op(1, 0, 32'h0000_FFF9, 16'h0002, 0, lat, q, r, e, bz);
`ifdef DIV_SIGNED_EN
        chk("div_n_lat", lat, 10);
        chk("div_n_quo", q, 32'h00FD);
        chk("div_n_rem", r, 32'h00FF);
        chk("div_n_err", e, 0);
`else
        chk("div_n_lat", lat, 2);
        chk("div_n_quo", q, 32'h001C);
        chk("div_n_rem", r, 32'h0004);
        chk("div_n_err", e, 1);
`endif

        do_op(1, 1, 32'hFFFF_8000, 16'h0001, 0, lat, q, r, e, bz);
`ifdef DIV_SIGNED_EN
        chk("div_min_lat", lat, 18);
        chk("div_min_quo", q, 32'h8000);
        chk("div_min_rem", r, 32'h0000);
        chk("div_min_err", e, 0);
`else
        chk("div_min_lat", lat, 2);
        chk("div_min_quo", q, 32'h001C);
        chk("div_min_rem", r, 32'h0004);
        chk("div_min_err", e, 1);
`endif

        do_op(1, 1, 32'h0000_8000, 16'h0001, 0, lat, q, r, e, bz);
        chk("div_ovf_lat", lat, 18);
        chk("div_ovf_quo", q, 32'h8000);
        chk("div_ovf_rem", r, 32'h0000);
`ifdef DIV_SIGNED_EN
        chk("div_ovf_err", e, 1);
`else
        chk("div_ovf_err", e, 0);
`endif

        @(negedge clk);
        wide = 1'b1;
        signed_op = 1'b0;
        dividend = 32'h0001_0000;
        divisor = 16'h0003;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quo", quotient, 0);
        chk("midrst_rem", remainder, 0);
        chk("midrst_err", div_error, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        do_op(0, 1, 32'h0000_0064, 16'h000A, 5, lat, q, r, e, bz);
        chk("post_rst_lat", lat, 18);
        chk("post_rst_quo", q, 32'h000A);
        chk("post_rst_rem", r, 32'h0000);
        chk("post_rst_err", e, 0);
        chk("post_rst_pulse", bz, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 SHALL have port clk  input  1  system clock, rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 SHALL have port signed_op  input  1  1 = DIV (signed), 0 = DIVU.
REQ-005 SHALL have port wide  input  1  1 = 32/16 divide, 0 = 16/8 divide.
REQ-006 SHALL have port dividend  input  32  narrow mode uses [15:0] only.
REQ-007 SHALL have port divisor  input  16  narrow mode uses [7:0] only.
REQ-008 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port quotient  output  16  narrow result in [7:0], [15:8] = 0.
REQ-011 SHALL have port remainder  output  16  narrow result in [7:0], [15:8] = 0.
REQ-012 SHALL have port div_error  output  1  valid with done; divide-by-zero or quotient overflow.

Function
REQ-013 SHALL implement states IDLE, PREP, ITER, FIXUP; IDLE->PREP on start; PREP->ITER or IDLE (error); ITER->FIXUP after N steps; FIXUP->IDLE.
REQ-014 SHALL latch signed_op, wide, dividend, divisor in the cycle start is accepted; later input changes have no effect.
REQ-015 SHALL, in PREP, take magnitudes of signed operands and flag error if divisor magnitude is zero or (unsigned magnitude) dividend high half >= divisor.
REQ-016 SHALL perform one restoring shift-subtract step per ITER cycle, N = 16 when wide, N = 8 when narrow.
REQ-017 SHALL, in FIXUP, negate quotient if operand signs differ and give remainder the sign of the dividend.
REQ-018 SHALL flag signed overflow in FIXUP when quotient is outside -0x8000..0x7FFF (wide) or -0x80..0x7F (narrow).
REQ-019 SHALL assert done for exactly one cycle: N+2 cycles after start normally, 2 cycles after start on PREP error.
REQ-020 SHALL leave quotient and remainder unchanged when div_error is set.
REQ-021 SHALL hold quotient, remainder, div_error stable after done until the next done.
REQ-022 SHALL ignore start while busy; start coincident with done is ignored (accepted only in IDLE).

Reset
REQ-023 SHALL on reset (any state, including mid-ITER) go to IDLE and drive busy, done, div_error to 0 and quotient, remainder to 0x0000.
REQ-024 SHALL accept a new start in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL, with DIV_SIGNED_EN defined, support signed division per REQ-015..REQ-018.
REQ-026 SHALL, without DIV_SIGNED_EN, ignore signed_op, treat all operations as unsigned, and omit sign/negate logic; latency unchanged.

Structure
REQ-027 SHALL place the state enum div_state_e and constants DIV_ITER_WIDE = 16, DIV_ITER_NARROW = 8 in the shared types package.
REQ-028 SHALL isolate one restoring step (partial remainder, divisor, width -> next remainder, quotient bit) in a combinational sub-module div_step.

Verification
REQ-029 SHALL verify DIVU wide 0x0001_0000 / 0x0003 -> quotient 0x5555, remainder 0x0001, div_error 0, done 18 cycles after start.
REQ-030 SHALL verify divisor 0x0000 (wide, unsigned) -> div_error 1, done 2 cycles after start, prior quotient/remainder retained.
REQ-031 SHALL verify DIVU wide 0x0003_0000 / 0x0002 -> div_error 1 at PREP (done 2 cycles after start).
REQ-032 SHALL verify DIV narrow 0xFFF9 / 0x02 -> quotient 0x00FD, remainder 0x00FF, done 10 cycles after start.
REQ-033 SHALL verify DIV wide 0xFFFF_8000 / 0x0001 -> quotient 0x8000, no error; 0x0000_8000 / 0x0001 -> div_error 1 at FIXUP.
REQ-034 SHALL verify reset asserted mid-ITER -> all outputs 0, then fresh start 0x0000_0064 / 0x000A (DIVU wide) -> quotient 0x000A, remainder 0x0000.
